bcd_convert_arbiter: RTL and testbench
======================================

// Module: bcd_convert_arbiter
// PURPOSE
//  Shares one sequential binary-to-BCD converter among NUM_REQ requesters
//  (e.g. register/ALU/PC values headed for the 7-segment display). It does
//  round-robin arbitration, captures the winner's 8-bit value, runs an
//  iterative shift-and-add-3 (double-dabble) conversion and returns
//  hundreds/tens/ones digits with a per-requester acknowledge pulse.
//  It sits between the processor datapath and the display driver.
// PARAMETERS
//  NUM_REQ   4   number of requesters; valid range 2..4
//  REQ_ID_W  2   width of ack_id; must equal clog2(NUM_REQ)
// PORTS
//  Clk       in   1            system clock; all state changes on rising edge
//  Rst       in   1            asynchronous, active-low reset
//  req       in   NUM_REQ      level request, one bit per requester
//  value_in  in   NUM_REQ*8    packed binary operands; requester i at [8*i+7:8*i]
//  ack       out  NUM_REQ      one-hot, one-cycle pulse: the served requester
//  ack_id    out  REQ_ID_W     index of the served requester; valid while done=1
//  done      out  1            one-cycle pulse: d100/d10/d1 updated this cycle
//  busy      out  1            1 while a conversion is in progress or in DONE
//  d100      out  4            BCD hundreds digit (0..2)
//  d10       out  4            BCD tens digit (0..9)
//  d1        out  4            BCD ones digit (0..9)
// BEHAVIOUR
//  Reset (Rst=0, asynchronous): state=IDLE; ack=0, ack_id=0, done=0, busy=0,
//   d100=d10=d1=0; shift counter=0; round-robin pointer=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//  - IDLE: at an edge where any req bit is set, select the winner: the first
//    set bit at or after the pointer, wrapping modulo NUM_REQ. Latch its
//    value_in and index, clear the BCD scratch register, set busy=1, then
//    go to SHIFT. If req=0, stay in IDLE.
//  - SHIFT: runs exactly 8 cycles, one bit per cycle, MSB first. Each cycle:
//    add 3 to every scratch nibble that is >=5, then shift {bcd,bin} left
//    by 1. After the 8th shift go to DONE and register the digits into
//    d100/d10/d1.
//  - DONE: lasts one cycle, with done=1, ack[id]=1 and ack_id=id. Next
//    edge: return to IDLE, done/ack drop, and pointer=(id+1) mod NUM_REQ.
//  Latency: request accepted at edge n -> done high in the cycle after edge
//   n+8. A held request is next accepted at edge n+10, so throughput is one
//   conversion per 10 cycles.
//  Handshake: a requester holds req until it sees its ack bit. The value is
//   sampled only at the accepting edge; later changes to value_in are
//   ignored. If req drops mid-conversion, the conversion still completes
//   and ack still pulses. A req held after ack is treated as a new request.
//  Outputs d100/d10/d1 keep the last result until the next DONE. They are
//   never partially updated during SHIFT.
//  Simultaneous requests: exactly one is granted per arbitration, with
//   strict round-robin fairness. No requester waits more than NUM_REQ-1
//   other conversions.
//  Requests asserted during SHIFT/DONE are not lost; they are evaluated at
//   the first IDLE edge.
//  Reset mid-operation: the conversion is aborted, no ack or done is
//   issued, and all reset values are restored immediately. The first edge
//   after Rst=1 arbitrates from pointer 0.
//  Max input 8'hFF=255, so d100 never exceeds 2. Unused upper bits of the
//   scratch register are zero.
// TESTING
//  1 Single req[0], value 8'h45 -> 9 cycles later done=1, ack=4'b0001,
//    digits 0/6/9; busy low one cycle after done.
//  2 Sequential single conversions on req[1]: 8'h63 -> 0/9/9,
//    8'h08 -> 0/0/8, 8'h00 -> 0/0/0, 8'h4D -> 0/7/7, 8'hFF -> 2/5/5.
//  3 req=4'b1111 held, distinct values -> acks in order 0,1,2,3,0,...,
//    done pulses exactly 10 cycles apart.
//  4 Pointer at 2, req=4'b0011 -> requester 0 served before 1; then a new
//    req[3] is served before req[1] is served again.
//  5 Change value_in[0] and drop req[0] at the 3rd SHIFT cycle -> the
//    result matches the value captured at acceptance, and ack[0] still
//    pulses.
//  6 Rst=0 asserted at SHIFT cycle 4 -> outputs zero immediately, no
//    done/ack issued; after release, a pending req[2] completes normally.

Source files
------------

// File: rtl/bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter
//
// Shares a single iterative binary-to-BCD converter (double-dabble) between
// NUM_REQ requesters. A round-robin arbiter picks one requester per
// conversion and captures its 8-bit operand. The converter then shifts
// that operand through the BCD scratch register for 8 cycles and returns
// the hundreds/tens/ones digits, together with a one-cycle acknowledge to
// the requester it served.
//
// Ports
//   clk_i       : system clock, all state changes on the rising edge
//   rst_ni      : asynchronous active-low reset
//   req_i       : level request, one bit per requester
//   value_in_i  : packed operands, requester i at [8*i+7:8*i]
//   ack_o       : one-hot, one-cycle pulse naming the served requester
//   ack_id_o    : index of the served requester, valid while done_o=1
//   done_o      : one-cycle pulse, digit outputs updated this cycle
//   busy_o      : high during SHIFT and DONE
//   d100_o      : BCD hundreds digit (0..2)
//   d10_o       : BCD tens digit
//   d1_o        : BCD ones digit
// -----------------------------------------------------------------------------
module bcd_convert_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*8-1:0]   value_in_i,
  output logic [NUM_REQ-1:0]     ack_o,
  output logic [REQ_ID_W-1:0]    ack_id_o,
  output logic                   done_o,
  output logic                   busy_o,
  output logic [3:0]             d100_o,
  output logic [3:0]             d10_o,
  output logic [3:0]             d1_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  stateT               state_q;
  logic [2:0]          bitCnt_q;
  logic [REQ_ID_W-1:0] ptr_q;
  logic [REQ_ID_W-1:0] id_q;
  logic [11:0]         bcd_q;
  logic [7:0]          bin_q;
  logic [NUM_REQ-1:0]  ack_q;
  logic                done_q;
  logic                busy_q;
  logic [3:0]          d100_q;
  logic [3:0]          d10_q;
  logic [3:0]          d1_q;

  logic [REQ_ID_W-1:0] winner_d;
  logic [REQ_ID_W-1:0] ptr_d;
  logic [11:0]         bcdAdj;
  logic [11:0]         bcd_d;
  logic [7:0]          bin_d;

  // Round-robin pick: scan from the pointer upwards and wrap, so the
  // requester just served (pointer = its index + 1) is looked at last.
  always_comb begin
    int  idx;
    logic found;
    winner_d = ptr_q;
    found    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_i[idx]) begin
        winner_d = REQ_ID_W'(idx);
        found    = 1'b1;
      end
    end
  end

  // Pointer moves to the requester after the one just served, modulo NUM_REQ.
  always_comb begin
    if (id_q == REQ_ID_W'(NUM_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = id_q + 1'b1;
    end
  end

  // One double-dabble step: correct every BCD nibble that would overflow
  // past 9 after doubling, then shift the combined {bcd,bin} left by one.
  // The hundreds nibble never exceeds 2 for an 8-bit input, so no carry
  // is lost from the top of the scratch register.
  always_comb begin
    bcdAdj = bcd_q;
    for (int n = 0; n < 3; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcdAdj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
    {bcd_d, bin_d} = {bcdAdj, bin_q} << 1;
  end

  // Control FSM and all registered outputs. Digits are written only on the
  // last shift, so the display never sees a half-converted value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bitCnt_q <= 3'd0;
      ptr_q    <= '0;
      id_q     <= '0;
      bcd_q    <= 12'd0;
      bin_q    <= 8'd0;
      ack_q    <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      d100_q   <= 4'd0;
      d10_q    <= 4'd0;
      d1_q     <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          ack_q  <= '0;
          if (|req_i) begin
            id_q     <= winner_d;
            bin_q    <= value_in_i[int'(winner_d)*8 +: 8];
            bcd_q    <= 12'd0;
            bitCnt_q <= 3'd0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (bitCnt_q == 3'd7) begin
            bitCnt_q <= 3'd0;
            d100_q   <= bcd_d[11:8];
            d10_q    <= bcd_d[7:4];
            d1_q     <= bcd_d[3:0];
            done_q   <= 1'b1;
            ack_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
            state_q  <= DONE;
          end else begin
            bitCnt_q <= bitCnt_q + 3'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_o    = ack_q;
  assign ack_id_o = id_q;
  assign done_o   = done_q;
  assign busy_o   = busy_q;
  assign d100_o   = d100_q;
  assign d10_o    = d10_q;
  assign d1_o     = d1_q;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bcd_convert_arbiter
//
// Directed bench for bcd_convert_arbiter. Inputs are driven and outputs
// sampled on the falling clock edge. Expected digits and grant order are
// hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_convert_arbiter;

  logic        clk;
  logic        rstN;
  logic [3:0]  req;
  logic [31:0] valueIn;
  logic [3:0]  ack;
  logic [1:0]  ackId;
  logic        done;
  logic        busy;
  logic [3:0]  d100;
  logic [3:0]  d10;
  logic [3:0]  d1;

  int checks;
  int errors;
  int cycleCount;
  int doneCycle;
  int prevDoneCycle;
  logic [11:0] prevDigits;

  bcd_convert_arbiter #(
    .NUM_REQ  (4),
    .REQ_ID_W (2)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rstN),
    .req_i      (req),
    .value_in_i (valueIn),
    .ack_o      (ack),
    .ack_id_o   (ackId),
    .done_o     (done),
    .busy_o     (busy),
    .d100_o     (d100),
    .d10_o      (d10),
    .d1_o       (d1)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure spacing between done pulses
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point: counts every check and reports any miss
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive request vector and one operand slot
  task automatic applyStimulus(input int idx, input logic [7:0] val,
                               input logic [3:0] reqVec);
    valueIn[idx*8 +: 8] = val;
    req = reqVec;
  endtask

  // Pulse reset and confirm every output is cleared
  task automatic resetDut();
    rstN = 1'b0;
    #1;
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstAck", 32'(ack), 32'd0);
    checkOutput("rstAckId", 32'(ackId), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDigits", 32'({d100, d10, d1}), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    prevDigits = 12'd0;
  endtask

  // Called at a falling edge just before the accepting edge. Follows one
  // conversion through SHIFT and DONE, then applies nextReq for the DONE cycle.
  task automatic serveExpect(input int expId, input logic [3:0] e100,
                             input logic [3:0] e10, input logic [3:0] e1,
                             input logic [3:0] nextReq);
    @(negedge clk);
    checkOutput("busyAfterAccept", 32'(busy), 32'd1);
    checkOutput("noDoneAtAccept", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("noDoneMidShift", 32'(done), 32'd0);
    checkOutput("digitsHeldMidShift", 32'({d100, d10, d1}), 32'(prevDigits));
    repeat (5) @(negedge clk);
    doneCycle = cycleCount;
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("ackOneHot", 32'(ack), 32'd1 << expId);
    checkOutput("ackId", 32'(ackId), 32'(expId));
    checkOutput("busyInDone", 32'(busy), 32'd1);
    checkOutput("d100", 32'(d100), 32'(e100));
    checkOutput("d10", 32'(d10), 32'(e10));
    checkOutput("d1", 32'(d1), 32'(e1));
    req = nextReq;
    @(negedge clk);
    checkOutput("doneDrops", 32'(done), 32'd0);
    checkOutput("ackDrops", 32'(ack), 32'd0);
    prevDigits = {e100, e10, e1};
  endtask

  initial begin
    logic [3:0] t3D100 [4];
    logic [3:0] t3D10  [4];
    logic [3:0] t3D1   [4];

    checks        = 0;
    errors        = 0;
    cycleCount    = 0;
    doneCycle     = 0;
    prevDoneCycle = 0;
    prevDigits    = 12'd0;
    req           = 4'b0000;
    valueIn       = 32'd0;
    rstN          = 1'b0;

    @(negedge clk);
    resetDut();

    // Single requester 0: 0x45 = 69
    applyStimulus(0, 8'h45, 4'b0001);
    serveExpect(0, 4'd0, 4'd6, 4'd9, 4'b0000);
    checkOutput("busyLowAfterDone", 32'(busy), 32'd0);

    // Back-to-back single conversions on requester 1
    applyStimulus(1, 8'h63, 4'b0010);
    serveExpect(1, 4'd0, 4'd9, 4'd9, 4'b0000);
    applyStimulus(1, 8'h08, 4'b0010);
    serveExpect(1, 4'd0, 4'd0, 4'd8, 4'b0000);
    applyStimulus(1, 8'h00, 4'b0010);
    serveExpect(1, 4'd0, 4'd0, 4'd0, 4'b0000);
    applyStimulus(1, 8'h4D, 4'b0010);
    serveExpect(1, 4'd0, 4'd7, 4'd7, 4'b0000);
    applyStimulus(1, 8'hFF, 4'b0010);
    serveExpect(1, 4'd2, 4'd5, 4'd5, 4'b0000);

    // All four held from pointer 0: grants 0,1,2,3,0 spaced 10 cycles
    resetDut();
    t3D100 = '{4'd0, 4'd2, 4'd0, 4'd2};
    t3D10  = '{4'd1, 4'd0, 4'd9, 4'd5};
    t3D1   = '{4'd2, 4'd0, 4'd9, 4'd5};
    valueIn = {8'd255, 8'd99, 8'd200, 8'd12};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serveExpect(k % 4, t3D100[k % 4], t3D10[k % 4], t3D1[k % 4],
                  (k == 4) ? 4'b0000 : 4'b1111);
      if (k > 0) begin
        checkOutput("donePeriod", 32'(doneCycle - prevDoneCycle), 32'd10);
      end
      prevDoneCycle = doneCycle;
    end

    // Pointer is 1 now; serve requester 1 to move it to 2
    req = 4'b0010;
    serveExpect(1, 4'd2, 4'd0, 4'd0, 4'b0000);
    // Pointer 2 with req 0011: requester 0 wraps ahead of requester 1
    req = 4'b0011;
    serveExpect(0, 4'd0, 4'd1, 4'd2, 4'b0010);
    // Requester 1 served; it stays asserted and requester 3 joins
    serveExpect(1, 4'd2, 4'd0, 4'd0, 4'b1010);
    // Pointer 2: requester 3 goes before requester 1 again
    serveExpect(3, 4'd2, 4'd5, 4'd5, 4'b0010);
    serveExpect(1, 4'd2, 4'd0, 4'd0, 4'b0000);

    // Operand changes and request drops during SHIFT: captured 123 wins
    applyStimulus(0, 8'd123, 4'b0001);
    @(negedge clk);
    checkOutput("t5Busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    applyStimulus(0, 8'd45, 4'b0000);
    repeat (6) @(negedge clk);
    checkOutput("t5Done", 32'(done), 32'd1);
    checkOutput("t5Ack", 32'(ack), 32'd1);
    checkOutput("t5Digits", 32'({d100, d10, d1}), 32'h123);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5IdleBusy", 32'(busy), 32'd0);
    checkOutput("t5IdleDone", 32'(done), 32'd0);

    // Reset in the 4th SHIFT cycle aborts; held requester 2 then completes
    applyStimulus(2, 8'd150, 4'b0100);
    @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("t6BusyBeforeReset", 32'(busy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6BusyCleared", 32'(busy), 32'd0);
    checkOutput("t6DigitsCleared", 32'({d100, d10, d1}), 32'd0);
    @(negedge clk);
    checkOutput("t6NoDone", 32'(done), 32'd0);
    checkOutput("t6NoAck", 32'(ack), 32'd0);
    rstN = 1'b1;
    prevDigits = 12'd0;
    serveExpect(2, 4'd1, 4'd5, 4'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
